// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//
// Shares one memory port between the i-cache refill path and the d-cache
// access path. When both caches ask at once, the one that was not served
// last wins. The winner's request is registered onto the memory port and
// held there until the bridge acknowledges. The returned data then goes back
// with a one-cycle ok pulse, and only the winner sees that pulse.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   i_req, i_addr            i-cache refill request (level) and fetch address
//   i_data, i_ok             32-bit instruction word, completion pulse
//   d_req, d_we, d_addr,
//   d_wdata, d_wmask         d-cache request (level), direction, address,
//                            write data, byte strobes
//   d_rdata, d_ok            64-bit read data (0 for writes), completion pulse
//   mem_req, mem_we,
//   mem_addr, mem_wdata,
//   mem_wmask                registered memory request toward the bridge
//   mem_rdata, mem_ok        memory read data, valid with the mem_ok pulse
//   state_dbg                current FSM state (IDLE=0, I_BUSY=1, D_BUSY=2,
//                            RESP=3)
//
// Handshake: a requester raises req and holds it and its fields until its ok
// pulse. mem_req stays high for the whole BUSY state. A single mem_ok cycle
// completes the transfer, and mem_ok seen outside BUSY is ignored. A
// requester that drops req mid-transaction still gets its ok pulse.

module cache_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    // i-cache side
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ok,
    // d-cache side
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_wmask,
    output logic [63:0] d_rdata,
    output logic        d_ok,
    // memory bridge side
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ok,
    // debug
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // 1 = the d-cache was granted most recently. Resets to 1 so that the
    // i-cache wins the first tie.
    logic   last_grant_d;
    // 1 = the transaction in flight (or being answered) belongs to the d-cache.
    logic   serving_d;

    logic   grant_i;
    logic   grant_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs. The outputs depend only on
    // registers, so no input reaches an output combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        mem_req    = 1'b0;
        i_ok       = 1'b0;
        d_ok       = 1'b0;

        unique case (state)
            IDLE: begin
                // On a tie, the i-cache wins only if the d-cache was served last.
                if (i_req && (!d_req || last_grant_d)) begin
                    grant_i    = 1'b1;
                    next_state = I_BUSY;
                end else if (d_req) begin
                    grant_d    = 1'b1;
                    next_state = D_BUSY;
                end
            end
            I_BUSY: begin
                mem_req = 1'b1;
                if (mem_ok) begin
                    next_state = RESP;
                end
            end
            D_BUSY: begin
                mem_req = 1'b1;
                if (mem_ok) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                i_ok       = !serving_d;
                d_ok       = serving_d;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Request latch. Captured on the grant edge and left untouched until
    // the next grant, so the memory fields stay stable through BUSY even if
    // the requester changes or drops its inputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr     <= 64'd0;
            mem_we       <= 1'b0;
            mem_wdata    <= 64'd0;
            mem_wmask    <= 8'd0;
            last_grant_d <= 1'b1;
            serving_d    <= 1'b0;
        end else if (grant_i) begin
            // Instruction fetches are always plain reads.
            mem_addr     <= i_addr;
            mem_we       <= 1'b0;
            mem_wdata    <= 64'd0;
            mem_wmask    <= 8'd0;
            last_grant_d <= 1'b0;
            serving_d    <= 1'b0;
        end else if (grant_d) begin
            mem_addr     <= d_addr;
            mem_we       <= d_we;
            mem_wdata    <= d_wdata;
            mem_wmask    <= d_wmask;
            last_grant_d <= 1'b1;
            serving_d    <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response data. The data is captured with mem_ok, so it is already
    // valid in the RESP cycle alongside the ok pulse. Each output is written
    // only by its own requester's transactions, so it holds its value
    // until that requester's next response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_data  <= 32'd0;
            d_rdata <= 64'd0;
        end else if (mem_ok) begin
            if (state == I_BUSY) begin
                // Fetch address bit 2 selects the 32-bit half of the 64-bit beat.
                i_data <= mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            end else if (state == D_BUSY) begin
                d_rdata <= mem_we ? 64'd0 : mem_rdata;
            end
        end
    end

endmodule
